// File: rtl/updown_counter_5bit.sv
// 5-bit up/down counter over the range [0, limit] with synchronous clamped load,
// a combinational terminal-count flag and a registered wrap pulse.
module updown_counter_5bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       load,
  input  logic [4:0] din,
  input  logic [4:0] limit,
  output logic [4:0] cnt,
  output logic       tc,
  output logic       wrap
);

  logic [4:0] step_operand;
  logic [4:0] step_val;
  logic       at_term;
  logic [4:0] load_val;
  logic [4:0] wrap_val;
  logic [4:0] cnt_nxt;
  logic       wrap_nxt;

  // Shared add/sub datapath: mode inverts the constant and supplies the carry-in.
  assign step_operand = 5'd1 ^ {5{mode}};
  assign step_val     = cnt + step_operand + {4'd0, mode};

  assign at_term  = mode ? (cnt == 5'd0) : (cnt >= limit);
  assign tc       = en & ~load & at_term;
  assign load_val = (din <= limit) ? din : limit;
  assign wrap_val = mode ? limit : 5'd0;

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (en) begin
      if (at_term) begin
        cnt_nxt  = wrap_val;
        wrap_nxt = 1'b1;
      end else begin
        cnt_nxt = step_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 5'd0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_5bit.sv
// Directed bench for updown_counter_5bit: a vector table for single-edge behaviour
// plus hand sequences for full-range wrap and asynchronous reset.
module tb_updown_counter_5bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, load;
  logic [4:0] din, limit;
  logic [4:0] cnt;
  logic       tc, wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       load;
    logic       en;
    logic       mode;
    logic [4:0] din;
    logic [4:0] limit;
    logic       exp_tc;
    logic [4:0] exp_cnt;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  updown_counter_5bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .load  (load),
    .din   (din),
    .limit (limit),
    .cnt   (cnt),
    .tc    (tc),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic e, input logic m, input logic [4:0] d,
                     input logic [4:0] lim, input logic t, input logic [4:0] c, input logic w);
    vec_t v;
    v.load = ld; v.en = e; v.mode = m; v.din = d; v.limit = lim;
    v.exp_tc = t; v.exp_cnt = c; v.exp_wrap = w;
    vecs.push_back(v);
  endtask

  initial begin
    int wraps;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; din = 5'd0; limit = 5'd0;

    //  load en mode din limit | tc cnt wrap
    // up wrap with limit 5
    add(0,1,0, 0, 5, 0, 1,0);
    add(0,1,0, 0, 5, 0, 2,0);
    add(0,1,0, 0, 5, 0, 3,0);
    add(0,1,0, 0, 5, 0, 4,0);
    add(0,1,0, 0, 5, 0, 5,0);
    add(0,1,0, 0, 5, 1, 0,1);
    add(0,1,0, 0, 5, 0, 1,0);
    // down wrap with limit 9
    add(1,0,0, 2, 9, 0, 2,0);
    add(0,1,1, 0, 9, 0, 1,0);
    add(0,1,1, 0, 9, 0, 0,0);
    add(0,1,1, 0, 9, 1, 9,1);
    add(0,1,1, 0, 9, 0, 8,0);
    add(0,0,1, 0, 9, 0, 8,0);
    // load clamp and priority over en
    add(1,1,0,20,10, 0,10,0);
    add(1,1,0, 3,10, 0, 3,0);
    // limit shrink, up then down
    add(1,0,0,12,20, 0,12,0);
    add(0,1,0, 0, 4, 1, 0,1);
    add(1,0,0,12,20, 0,12,0);
    add(0,1,1, 0, 4, 0,11,0);
    // load while at terminal suppresses wrap
    add(1,1,0, 2, 4, 0, 2,0);
    // mode flip with no dead cycle
    add(0,1,0, 0, 4, 0, 3,0);
    add(0,1,1, 0, 4, 0, 2,0);
    // din equal to and above limit
    add(1,0,0, 4, 4, 0, 4,0);
    add(1,0,0, 5, 4, 0, 4,0);

    #12;
    check("reset_cnt", cnt, 5'd0);
    check("reset_wrap", {4'd0, wrap}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      load = vecs[i].load; en = vecs[i].en; mode = vecs[i].mode;
      din = vecs[i].din; limit = vecs[i].limit;
      #1;
      check($sformatf("v%0d_tc", i), {4'd0, tc}, {4'd0, vecs[i].exp_tc});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", i), cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_wrap", i), {4'd0, wrap}, {4'd0, vecs[i].exp_wrap});
    end

    // full range: 32 up edges from 0 give exactly one wrap, landing on 0
    @(negedge clk);
    load = 1'b1; en = 1'b0; mode = 1'b0; din = 5'd0; limit = 5'd31;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (wrap) wraps++;
      check($sformatf("full_cnt%0d", k), cnt, 5'(k));
      @(negedge clk);
    end
    check("full_wraps", 5'(wraps), 5'd1);
    mode = 1'b1;
    #1;
    check("full_tc_down", {4'd0, tc}, 5'd1);
    @(posedge clk);
    #1;
    check("full_down_cnt", cnt, 5'd31);
    check("full_down_wrap", {4'd0, wrap}, 5'd1);

    // async reset between edges at cnt=7
    @(negedge clk);
    load = 1'b1; en = 1'b0; mode = 1'b0; din = 5'd7; limit = 5'd20;
    @(posedge clk);
    #1;
    check("pre_rst_cnt", cnt, 5'd7);
    @(negedge clk);
    load = 1'b0; en = 1'b1; limit = 5'd0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_cnt", cnt, 5'd0);
    check("async_wrap", {4'd0, wrap}, 5'd0);
    check("rst_tc", {4'd0, tc}, 5'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mode = (k >= 2);
      #1;
      @(posedge clk);
      #1;
      check($sformatf("lim0_cnt%0d", k), cnt, 5'd0);
      check($sformatf("lim0_wrap%0d", k), {4'd0, wrap}, 5'd1);
    end

    // wrap drops once en falls
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("idle_wrap", {4'd0, wrap}, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
